// File: rtl/pkt_rr_arb.sv
// Packet-granular round-robin arbiter: two buffered 134-bit packet streams merged onto
// one output, complete packets only, starts gated on downstream fill, bad packets dropped.

module pkt_rr_fifo #(
  parameter int W  = 134,
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic [AW:0]   level_o
);
  localparam logic [AW:0] FULL = (AW+1)'(1 << AW);

  logic [W-1:0]  mem_q [1 << AW];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push = push_i && (level_q != FULL);
    do_pop  = pop_i && (level_q != '0);
    level_d = level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_q + {{(AW-1){1'b0}}, do_push};
      rptr_q  <= rptr_q + {{(AW-1){1'b0}}, do_pop};
      level_q <= level_d;
    end
  end

  // First-word-fall-through view so the FSM sees the tail marker before popping it.
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;
endmodule

module pkt_rr_arb #(
  parameter int         FIFO_AW      = 8,
  parameter int         DESC_AW      = 4,
  parameter logic [7:0] USEDW_TH     = 8'd200,
  parameter int         READY_MARGIN = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [133:0] in0_data,
  input  logic         in0_data_wr,
  input  logic         in0_valid,
  input  logic         in0_valid_wr,
  output logic         in0_ready,
  input  logic [133:0] in1_data,
  input  logic         in1_data_wr,
  input  logic         in1_valid,
  input  logic         in1_valid_wr,
  output logic         in1_ready,
  input  logic [7:0]   pktout_usedw,
  output logic [133:0] out_data,
  output logic         out_data_wr,
  output logic         out_valid,
  output logic         out_valid_wr,
  output logic [31:0]  pkt_cnt0,
  output logic [31:0]  pkt_cnt1,
  output logic [31:0]  drop_cnt
);
  localparam logic [FIFO_AW:0] DAT_FULL = (FIFO_AW+1)'(1 << FIFO_AW);
  localparam logic [FIFO_AW:0] DAT_RSV  = DAT_FULL - 1'b1;
  localparam logic [FIFO_AW:0] RDY_LVL  = (FIFO_AW+1)'((1 << FIFO_AW) - READY_MARGIN);
  localparam logic [DESC_AW:0] DSC_FULL = (DESC_AW+1)'(1 << DESC_AW);
  localparam logic [DESC_AW:0] DSC_RDY  = DSC_FULL - 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DROP} state_t;

  logic [133:0]     in_data  [2];
  logic [1:0]       data_wr, valid, valid_wr, rdy;
  logic [133:0]     dat_head [2];
  logic [FIFO_AW:0] dat_lvl  [2];
  logic [DESC_AW:0] dsc_lvl  [2];
  logic [1:0]       dsc_head, dsc_pop, dat_pop;

  assign in_data[0] = in0_data;
  assign in_data[1] = in1_data;
  assign data_wr    = {in1_data_wr, in0_data_wr};
  assign valid      = {in1_valid, in0_valid};
  assign valid_wr   = {in1_valid_wr, in0_valid_wr};
  assign in0_ready  = rdy[0];
  assign in1_ready  = rdy[1];

  for (genvar g = 0; g < 2; g++) begin : g_in
    logic is_tail, word_ok, word_drop, dat_push, dsc_push, dsc_wdata;
    logic bad_q, bad_d, rdy_q, rdy_d;

    // One data slot stays reserved for tails, so a truncated packet still ends in a tail
    // and the drop path can find the packet boundary.
    always_comb begin
      is_tail   = in_data[g][133:132] == 2'b10;
      word_ok   = is_tail ? (dat_lvl[g] < DAT_FULL) : (!bad_q && (dat_lvl[g] < DAT_RSV));
      dat_push  = data_wr[g] && word_ok;
      word_drop = data_wr[g] && !word_ok;
      dsc_push  = valid_wr[g] && (dsc_lvl[g] != DSC_FULL);
      dsc_wdata = valid[g] && !bad_q && !word_drop;
      bad_d     = valid_wr[g] ? 1'b0 : (bad_q || word_drop);
      rdy_d     = (dat_lvl[g] <= RDY_LVL) && (dsc_lvl[g] <= DSC_RDY);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        bad_q <= 1'b0;
        rdy_q <= 1'b0;
      end else begin
        bad_q <= bad_d;
        rdy_q <= rdy_d;
      end
    end

    assign rdy[g] = rdy_q;

    pkt_rr_fifo #(.W(134), .AW(FIFO_AW)) u_dat (
      .clk_i(clk), .rst_i(rst), .push_i(dat_push), .wdata_i(in_data[g]),
      .pop_i(dat_pop[g]), .rdata_o(dat_head[g]), .level_o(dat_lvl[g])
    );

    pkt_rr_fifo #(.W(1), .AW(DESC_AW)) u_dsc (
      .clk_i(clk), .rst_i(rst), .push_i(dsc_push), .wdata_i(dsc_wdata),
      .pop_i(dsc_pop[g]), .rdata_o(dsc_head[g]), .level_o(dsc_lvl[g])
    );
  end

  state_t       state_q;
  logic         sel_q, rr_last_q;
  logic [133:0] out_data_q;
  logic         out_data_wr_q, out_valid_q, out_valid_wr_q;
  logic [31:0]  pkt_cnt0_q, pkt_cnt1_q, drop_cnt_q;
  logic [1:0]   cand;
  logic         pick, cur_tail;
  logic [133:0] cur_word;

  always_comb begin
    cand     = {dsc_lvl[1] != '0, dsc_lvl[0] != '0};
    pick     = (cand == 2'b11) ? ~rr_last_q : cand[1];
    cur_word = dat_head[sel_q];
    cur_tail = cur_word[133:132] == 2'b10;
    dsc_pop  = '0;
    dat_pop  = '0;
    case (state_q)
      ST_IDLE: if (cand[pick] && (!dsc_head[pick] || (pktout_usedw < USEDW_TH)))
                 dsc_pop[pick] = 1'b1;
      ST_SEND,
      ST_DROP: if (dat_lvl[sel_q] != '0) dat_pop[sel_q] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      sel_q          <= 1'b0;
      rr_last_q      <= 1'b1;
      out_data_q     <= '0;
      out_data_wr_q  <= 1'b0;
      out_valid_q    <= 1'b0;
      out_valid_wr_q <= 1'b0;
      pkt_cnt0_q     <= '0;
      pkt_cnt1_q     <= '0;
      drop_cnt_q     <= '0;
    end else begin
      out_data_wr_q  <= 1'b0;
      out_valid_q    <= 1'b0;
      out_valid_wr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (dsc_pop[pick]) begin
            sel_q <= pick;
            if (dsc_head[pick]) begin
              state_q   <= ST_SEND;
              rr_last_q <= pick;
            end else begin
              state_q <= ST_DROP;
            end
          end
        end
        ST_SEND: begin
          if (dat_pop[sel_q]) begin
            out_data_q    <= cur_word;
            out_data_wr_q <= 1'b1;
            if (cur_tail) begin
              out_valid_q    <= 1'b1;
              out_valid_wr_q <= 1'b1;
              if (sel_q) pkt_cnt1_q <= pkt_cnt1_q + 32'd1;
              else       pkt_cnt0_q <= pkt_cnt0_q + 32'd1;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (dat_pop[sel_q] && cur_tail) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_data     = out_data_q;
  assign out_data_wr  = out_data_wr_q;
  assign out_valid    = out_valid_q;
  assign out_valid_wr = out_valid_wr_q;
  assign pkt_cnt0     = pkt_cnt0_q;
  assign pkt_cnt1     = pkt_cnt1_q;
  assign drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_pkt_rr_arb.sv
// Scoreboard bench for pkt_rr_arb: good packets queued per input at issue time, a monitor
// matches every output packet against the front of its input's queue.

module tb_pkt_rr_arb;
  logic         clk = 1'b0;
  logic         rst;
  logic [133:0] in0_data, in1_data, out_data;
  logic         in0_data_wr, in0_valid, in0_valid_wr, in0_ready;
  logic         in1_data_wr, in1_valid, in1_valid_wr, in1_ready;
  logic [7:0]   pktout_usedw;
  logic         out_data_wr, out_valid, out_valid_wr;
  logic [31:0]  pkt_cnt0, pkt_cnt1, drop_cnt;

  always #5 clk = ~clk;

  pkt_rr_arb #(.FIFO_AW(8), .DESC_AW(4), .USEDW_TH(8'd200), .READY_MARGIN(64)) dut (
    .clk(clk), .rst(rst),
    .in0_data(in0_data), .in0_data_wr(in0_data_wr), .in0_valid(in0_valid),
    .in0_valid_wr(in0_valid_wr), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_data_wr(in1_data_wr), .in1_valid(in1_valid),
    .in1_valid_wr(in1_valid_wr), .in1_ready(in1_ready),
    .pktout_usedw(pktout_usedw),
    .out_data(out_data), .out_data_wr(out_data_wr), .out_valid(out_valid),
    .out_valid_wr(out_valid_wr),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .drop_cnt(drop_cnt)
  );

  int           total = 0, bad = 0;
  logic [133:0] w0[$], w1[$];
  int           src_log[$];
  int           wr_seen = 0;
  bit           in_pkt = 1'b0;
  int           cur_src = 0;
  int           exp_cnt[2];
  int           exp_drop = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: reassembles output packets and checks them against the expected queues.
  always @(negedge clk) begin
    logic [133:0] e;
    if (rst) begin
      in_pkt = 1'b0;
    end else if (out_data_wr) begin
      wr_seen++;
      if (!in_pkt) begin
        total++;
        if (w0.size() > 0 && w0[0] == out_data) begin cur_src = 0; in_pkt = 1'b1; end
        else if (w1.size() > 0 && w1[0] == out_data) begin cur_src = 1; in_pkt = 1'b1; end
        else begin
          bad++;
          $display("FAIL unexpected_head: got %h expected a queued head word", out_data);
        end
      end
      if (in_pkt) begin
        e = (cur_src == 0) ? w0.pop_front() : w1.pop_front();
        total++;
        if (out_data != e) begin
          bad++;
          $display("FAIL out_data: got %h expected %h", out_data, e);
        end
        chk("out_valid_wr", out_valid_wr, e[133:132] == 2'b10);
        if (e[133:132] == 2'b10) begin
          chk("out_valid", out_valid, 1);
          in_pkt = 1'b0;
          src_log.push_back(cur_src);
        end
      end
    end else begin
      if (in_pkt) chk("no_gap_in_packet", out_data_wr, 1);
      if (out_valid_wr) chk("stray_out_valid_wr", out_valid_wr, 0);
    end
  end

  task automatic drive(input int port, input logic [133:0] d, input logic dw,
                       input logic v, input logic vw);
    if (port == 0) begin
      in0_data = d; in0_data_wr = dw; in0_valid = v; in0_valid_wr = vw;
    end else begin
      in1_data = d; in1_data_wr = dw; in1_valid = v; in1_valid_wr = vw;
    end
  endtask

  task automatic send_pkt(input int port, input int len, input bit good,
                          input bit fwd, input bit wait_rdy);
    logic [133:0] d;
    logic [1:0]   typ;
    int           n = 0;
    if (wait_rdy) begin
      while (!(port == 0 ? in0_ready : in1_ready) && n < 3000) begin
        @(posedge clk); #1; n++;
      end
      if (n >= 3000) chk("ready_timeout", 0, 1);
    end
    for (int i = 0; i < len; i++) begin
      typ = (i == 0) ? 2'b01 : ((i == len - 1) ? 2'b10 : 2'b11);
      d = {typ, $urandom, $urandom, $urandom, $urandom, 4'(port)};
      drive(port, d, 1'b1, good, i == len - 1);
      if (fwd) begin
        if (port == 0) w0.push_back(d); else w1.push_back(d);
      end
      @(posedge clk); #1;
    end
    drive(port, '0, 1'b0, 1'b0, 1'b0);
    if (fwd) exp_cnt[port]++; else exp_drop++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    w0.delete(); w1.delete(); src_log.delete();
    exp_cnt[0] = 0; exp_cnt[1] = 0; exp_drop = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain(input int extra);
    int n = 0;
    while ((w0.size() > 0 || w1.size() > 0 || in_pkt) && n < 5000) begin
      @(posedge clk); n++;
    end
    if (n >= 5000) chk("drain_timeout", 0, 1);
    repeat (extra) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, n, ws;
    rst = 1'b1;
    pktout_usedw = '0;
    drive(0, '0, 1'b0, 1'b0, 1'b0);
    drive(1, '0, 1'b0, 1'b0, 1'b0);
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in0_ready", in0_ready, 0);
    chk("rst_in1_ready", in1_ready, 0);
    chk("rst_out_data_wr", out_data_wr, 0);
    chk("rst_out_data", out_data == '0, 1);
    chk("rst_counters", pkt_cnt0 + pkt_cnt1 + drop_cnt, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", {in1_ready, in0_ready}, 3);
    #1;

    // 1: single packet, latency and contiguity
    send_pkt(0, 4, 1'b1, 1'b1, 1'b1);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_data_wr && lat < 20);
    chk("first_word_latency", lat, 3);
    drain(5);
    chk("t1_pkt_cnt0", pkt_cnt0, 1);
    chk("t1_pkt_cnt1", pkt_cnt1, 0);

    // 2: alternation with both inputs backlogged
    do_reset();
    pktout_usedw = 8'd200;
    for (int i = 0; i < 3; i++) send_pkt(0, $urandom_range(2, 6), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send_pkt(1, $urandom_range(2, 6), 1'b1, 1'b1, 1'b1);
    pktout_usedw = 8'd0;
    drain(5);
    chk("t2_order_len", src_log.size(), 6);
    for (int i = 0; i < 6 && i < src_log.size(); i++) chk("t2_order", src_log[i], i % 2);
    chk("t2_pkt_cnt0", pkt_cnt0, 3);
    chk("t2_pkt_cnt1", pkt_cnt1, 3);

    // 3: bad packet dropped, following good one intact
    do_reset();
    send_pkt(1, 4, 1'b0, 1'b0, 1'b1);
    send_pkt(1, 5, 1'b1, 1'b1, 1'b1);
    drain(20);
    chk("t3_drop_cnt", drop_cnt, 1);
    chk("t3_pkt_cnt1", pkt_cnt1, 1);

    // 4: usedw gating at start only
    do_reset();
    pktout_usedw = 8'd200;
    send_pkt(0, 10, 1'b1, 1'b1, 1'b1);
    ws = wr_seen;
    repeat (20) @(posedge clk);
    chk("t4_blocked", wr_seen - ws, 0);
    pktout_usedw = 8'd199;
    n = 0;
    while (!in_pkt && n < 20) begin @(posedge clk); n++; end
    chk("t4_started", in_pkt, 1);
    pktout_usedw = 8'd255;
    drain(5);
    chk("t4_pkt_cnt0", pkt_cnt0, 1);
    pktout_usedw = 8'd0;

    // 5: overflow by ignoring ready
    do_reset();
    pktout_usedw = 8'd200;
    send_pkt(0, 300, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_in0_ready_low", in0_ready, 0);
    chk("t5_in1_ready_high", in1_ready, 1);
    #1;
    pktout_usedw = 8'd0;
    repeat (400) @(posedge clk);
    #1;
    chk("t5_drop_cnt", drop_cnt, 1);
    chk("t5_pkt_cnt0", pkt_cnt0, 0);
    chk("t5_in0_ready_back", in0_ready, 1);
    send_pkt(0, 6, 1'b1, 1'b1, 1'b1);
    drain(5);
    chk("t5_pkt_cnt0_after", pkt_cnt0, 1);

    // 6: reset mid-packet
    do_reset();
    send_pkt(0, 8, 1'b1, 1'b1, 1'b1);
    n = 0;
    while (!in_pkt && n < 20) begin @(posedge clk); n++; end
    chk("t6_started", in_pkt, 1);
    #1;
    rst = 1'b1;
    w0.delete(); w1.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_out_data_wr", out_data_wr, 0);
    chk("t6_out_valid_wr", out_valid_wr, 0);
    chk("t6_out_data", out_data == '0, 1);
    chk("t6_counters", pkt_cnt0 + pkt_cnt1 + drop_cnt, 0);
    ws = wr_seen;
    repeat (10) @(posedge clk);
    chk("t6_quiet", wr_seen - ws, 0);
    #1;
    send_pkt(0, 5, 1'b1, 1'b1, 1'b1);
    drain(5);
    chk("t6_pkt_cnt0", pkt_cnt0, 1);

    // Random traffic against the per-input reference queues
    do_reset();
    for (int k = 0; k < 40; k++) begin
      int  port, len;
      bit  good;
      port = $urandom_range(0, 1);
      len  = $urandom_range(2, 12);
      good = ($urandom_range(0, 4) != 0);
      if (k % 7 == 0) pktout_usedw = 8'($urandom_range(180, 255));
      else if (k % 7 == 3) pktout_usedw = 8'($urandom_range(0, 199));
      send_pkt(port, len, good, good, 1'b1);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    pktout_usedw = 8'd0;
    drain(40);
    chk("rnd_pkt_cnt0", pkt_cnt0, exp_cnt[0]);
    chk("rnd_pkt_cnt1", pkt_cnt1, exp_cnt[1]);
    chk("rnd_drop_cnt", drop_cnt, exp_drop);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
